// File: rtl/game_round_ctrl.sv
// game_round_ctrl: top-level sequencer for the note-memory game datapath.
// Builds an eight-note pattern, loads it, starts the game, then debounces the
// raw keypad into single-cycle key events while counting rounds, watching for
// an idle timeout and reporting game completion.
// Build option: define FIXED_PATTERN_EN to load FIXED_PATTERN every round
// instead of the LFSR-derived pattern.
module game_round_ctrl #(
  parameter int          DEBOUNCE_CYCLES = 4,
  parameter int          TIMEOUT_CYCLES  = 1000,
  parameter int          NUM_ROUNDS      = 3,
  parameter logic [31:0] LFSR_SEED       = 32'hACE12345,
  parameter logic [31:0] FIXED_PATTERN   = 32'h87654321
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_req,
  input  logic [3:0]  key_raw,
  input  logic        game_end_in,
  output logic        game_reset_out,
  output logic [31:0] pattern_out,
  output logic        write_enable_out,
  output logic        game_start_out,
  output logic [3:0]  keypad_input_out,
  output logic        keypad_enable_out,
  output logic [2:0]  state_out,
  output logic [2:0]  round_out,
  output logic        timeout_out,
  output logic        done_out
);

  localparam logic [31:0] LFSR_POLY = 32'h80200003;
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_MAX    = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [TO_W-1:0] TO_MAX    = TO_W'(TIMEOUT_CYCLES);
  localparam logic [2:0]      ROUND_MAX = 3'(NUM_ROUNDS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLR     = 3'd1,
    S_LOAD    = 3'd2,
    S_START   = 3'd3,
    S_PLAY    = 3'd4,
    S_DONE    = 3'd5,
    S_TIMEOUT = 3'd6,
    S_BAD     = 3'd7
  } state_t;

  state_t          state, next_state;
  logic            start_req_p0, start_req_p1, start_rise;
  logic [31:0]     lfsr;
  logic [31:0]     load_pattern;
  logic [3:0]      key_prev_p0;
  logic [DB_W-1:0] run_cnt, run_len;
  logic            armed, armed_next, key_stable, key_evt;
  logic [TO_W-1:0] idle_cnt, idle_cnt_next;
  logic [2:0]      round_next;
  logic [3:0]      keypad_input_next;
  logic            keypad_enable_next;

  // start_req is captured first so the edge detector never sees a raw async input
  assign start_rise = start_req_p0 & ~start_req_p1;
  assign state_out  = state;

`ifdef FIXED_PATTERN_EN
  assign load_pattern = FIXED_PATTERN;
`else
  // Notes map 3 random bits onto 1..8 so that code 0 (silence) never appears.
  function automatic logic [3:0] note_of(input logic [2:0] r);
    return {1'b0, r} + 4'd1;
  endfunction

  // Pattern candidate derived from the free-running LFSR
  always_comb begin
    load_pattern = '0;
    for (int i = 0; i < 8; i++) begin
      load_pattern[4*i +: 4] = note_of(lfsr[4*i +: 3]);
    end
  end

  // FIXED_PATTERN only matters in the fixed-pattern build.
  logic unused_fixed_pattern;
  assign unused_fixed_pattern = ^FIXED_PATTERN;
`endif

  // Start-request edge capture and LFSR free-run (shifts every cycle out of reset)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_req_p0 <= 1'b0;
      start_req_p1 <= 1'b0;
      lfsr         <= LFSR_SEED;
    end else begin
      start_req_p0 <= start_req;
      start_req_p1 <= start_req_p0;
      lfsr         <= lfsr[0] ? ({1'b0, lfsr[31:1]} ^ LFSR_POLY) : {1'b0, lfsr[31:1]};
    end
  end

  // Debounce: run length of the current key code and the press/re-arm decision
  always_comb begin
    if (key_raw == key_prev_p0) begin
      run_len = (run_cnt == DB_MAX) ? DB_MAX : run_cnt + 1'b1;
    end else begin
      run_len = DB_W'(1);
    end
    key_stable = (run_len == DB_MAX);
    key_evt    = key_stable && (key_raw != 4'd0) && armed;
    armed_next = armed;
    if (key_evt) begin
      armed_next = 1'b0;
    end else if (key_stable && (key_raw == 4'd0)) begin
      armed_next = 1'b1;
    end
  end

  // Debounce history; a key held across reset must be released before it counts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_prev_p0 <= 4'd0;
      run_cnt     <= '0;
      armed       <= 1'b0;
    end else begin
      key_prev_p0 <= key_raw;
      run_cnt     <= run_len;
      armed       <= armed_next;
    end
  end

  // Next-state and next-output decisions; game end beats key beats timeout
  always_comb begin
    next_state         = state;
    round_next         = round_out;
    idle_cnt_next      = idle_cnt;
    keypad_enable_next = 1'b0;
    keypad_input_next  = keypad_input_out;
    case (state)
      S_IDLE: begin
        if (start_rise) next_state = S_CLR;
      end
      S_CLR: begin
        next_state = S_LOAD;
      end
      S_LOAD: begin
        next_state    = S_START;
        idle_cnt_next = '0;
      end
      S_START: begin
        next_state    = S_PLAY;
        idle_cnt_next = '0;
      end
      S_PLAY: begin
        if (game_end_in) begin
          round_next = round_out + 3'd1;
          next_state = (round_next == ROUND_MAX) ? S_DONE : S_CLR;
        end else if (key_evt) begin
          keypad_enable_next = 1'b1;
          keypad_input_next  = key_raw;
          idle_cnt_next      = '0;
        end else begin
          idle_cnt_next = idle_cnt + 1'b1;
          if (idle_cnt_next == TO_MAX) next_state = S_TIMEOUT;
        end
      end
      S_DONE, S_TIMEOUT: begin
        if (start_rise) begin
          next_state = S_CLR;
          round_next = '0;
        end
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // State register and registered outputs, decoded from the state being entered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= S_IDLE;
      idle_cnt          <= '0;
      round_out         <= 3'd0;
      game_reset_out    <= 1'b0;
      write_enable_out  <= 1'b0;
      game_start_out    <= 1'b0;
      pattern_out       <= 32'd0;
      keypad_enable_out <= 1'b0;
      keypad_input_out  <= 4'd0;
      timeout_out       <= 1'b0;
      done_out          <= 1'b0;
    end else begin
      state             <= next_state;
      idle_cnt          <= idle_cnt_next;
      round_out         <= round_next;
      game_reset_out    <= (next_state == S_CLR);
      write_enable_out  <= (next_state == S_LOAD);
      game_start_out    <= (next_state == S_START);
      if (next_state == S_LOAD) pattern_out <= load_pattern;
      keypad_enable_out <= keypad_enable_next;
      keypad_input_out  <= keypad_input_next;
      timeout_out       <= (next_state == S_TIMEOUT);
      done_out          <= (next_state == S_DONE);
    end
  end

endmodule
